// File: rtl/uart_cmd_if.sv
// uart_cmd_if: byte stream in from the UART receiver, framed command out to the APB master.
interface uart_cmd_if;
  logic [7:0] rx_data;
  logic rx_data_valid;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic busy;
  logic frame_err;
  logic timeout_err;
  logic overrun_err;
  modport master (
    input rx_data, rx_data_valid, cmd_ready,
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, busy, frame_err, timeout_err, overrun_err
  );
  modport slave (
    output rx_data, rx_data_valid, cmd_ready,
    input cmd_valid, cmd_write, cmd_addr, cmd_wdata, busy, frame_err, timeout_err, overrun_err
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: assembles 'W'/'R' framed commands from UART bytes and hands them off via valid/ready.
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 17360,
  parameter logic [7:0] WR_HDR = 8'h57,
  parameter logic [7:0] RD_HDR = 8'h52
) (
  input logic clk,
  input logic rst_n,
  uart_cmd_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;
  localparam logic [15:0] GAP_MAX = 16'(TIMEOUT_CYCLES - 1);
  logic [1:0] state;
  logic [1:0] cnt;
  logic [15:0] gap;
  logic hdr_ok;
  assign hdr_ok = (bus.rx_data == WR_HDR) || (bus.rx_data == RD_HDR);
  assign bus.cmd_valid = state == HOLD;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      gap <= '0;
      bus.cmd_write <= 1'b0;
      bus.cmd_addr <= '0;
      bus.cmd_wdata <= '0;
      bus.frame_err <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.overrun_err <= 1'b0;
    end else begin
      bus.frame_err <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.overrun_err <= 1'b0;
      case (state)
        IDLE: if (bus.rx_data_valid) begin
          if (hdr_ok) begin
            state <= ADDR;
            bus.cmd_write <= bus.rx_data == WR_HDR;
            bus.cmd_addr <= '0;
            bus.cmd_wdata <= '0;
            cnt <= '0;
            gap <= '0;
          end else bus.frame_err <= 1'b1;
        end
        ADDR, DATA: if (bus.rx_data_valid) begin
          gap <= '0;
          cnt <= cnt + 2'd1;
          if (state == ADDR) bus.cmd_addr <= {bus.cmd_addr[23:0], bus.rx_data};
          else bus.cmd_wdata <= {bus.cmd_wdata[23:0], bus.rx_data};
          if (cnt == 2'd3) state <= (state == ADDR && bus.cmd_write) ? DATA : HOLD;
        end else if (gap == GAP_MAX) begin
          // a byte in the expiry cycle takes the branch above, so it always wins over the timeout
          bus.timeout_err <= 1'b1;
          state <= IDLE;
          bus.cmd_write <= 1'b0;
          bus.cmd_addr <= '0;
          bus.cmd_wdata <= '0;
        end else gap <= gap + 16'd1;
        default: begin
          bus.overrun_err <= bus.rx_data_valid;
          if (bus.cmd_ready) state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: table-driven frame vectors plus directed timeout/overrun/reset sequences.
module tb_uart_cmd_decoder;
  localparam int T = 40;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int fe_cnt = 0, to_cnt = 0, ov_cnt = 0, multi = 0, wide = 0;
  int exp_fe = 0;
  logic pfe = 1'b0, pto = 1'b0, pov = 1'b0;
  uart_cmd_if bus();
  uart_cmd_decoder #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    fe_cnt += int'(bus.frame_err);
    to_cnt += int'(bus.timeout_err);
    ov_cnt += int'(bus.overrun_err);
    if (int'(bus.frame_err) + int'(bus.timeout_err) + int'(bus.overrun_err) > 1) multi++;
    if ((bus.frame_err && pfe) || (bus.timeout_err && pto) || (bus.overrun_err && pov)) wide++;
    pfe = bus.frame_err;
    pto = bus.timeout_err;
    pov = bus.overrun_err;
  end
  typedef struct {
    logic [71:0] bytes;
    int n;
    bit ev;
    bit ew;
    logic [31:0] ea;
    logic [31:0] ed;
  } vec_t;
  vec_t vecs[6];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_data_valid = 1'b1;
    @(negedge clk);
    bus.rx_data_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic accept();
    @(negedge clk);
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    check("accept_valid_low", 32'(bus.cmd_valid), 0);
    check("accept_busy_low", 32'(bus.busy), 0);
  endtask
  task automatic check_cmd(input string name, input bit w, input logic [31:0] a, input logic [31:0] d);
    check({name, "_valid"}, 32'(bus.cmd_valid), 1);
    check({name, "_write"}, 32'(bus.cmd_write), 32'(w));
    check({name, "_addr"}, bus.cmd_addr, a);
    check({name, "_wdata"}, bus.cmd_wdata, d);
  endtask
  initial begin
    logic [71:0] tmp;
    logic [31:0] sa, sd;
    bit stable;
    bus.rx_data = 8'h00;
    bus.rx_data_valid = 1'b0;
    bus.cmd_ready = 1'b0;
    vecs[0] = '{72'h57_12345678_DEADBEEF, 9, 1'b1, 1'b1, 32'h12345678, 32'hDEADBEEF};
    vecs[1] = '{72'h52_00001004_00000000, 5, 1'b1, 1'b0, 32'h00001004, 32'h0};
    vecs[2] = '{72'h41_00000000_00000000, 1, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{72'h57_A5C3E1F0_01020304, 9, 1'b1, 1'b1, 32'hA5C3E1F0, 32'h01020304};
    vecs[4] = '{72'h00_00000000_00000000, 1, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[5] = '{72'h52_FFFFFFFF_00000000, 5, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0};
    idle(3);
    check("rst_valid", 32'(bus.cmd_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_addr", bus.cmd_addr, 0);
    check("rst_wdata", bus.cmd_wdata, 0);
    check("rst_write", 32'(bus.cmd_write), 0);
    rst_n = 1'b1;
    for (int v = 0; v < 6; v++) begin
      tmp = vecs[v].bytes;
      for (int i = 0; i < vecs[v].n; i++) begin
        if (i != 0) idle(19);
        send_byte(tmp[71 - 8*i -: 8]);
      end
      if (vecs[v].ev) begin
        check_cmd($sformatf("vec%0d", v), vecs[v].ew, vecs[v].ea, vecs[v].ed);
        idle(2);
        accept();
      end else begin
        exp_fe++;
        check($sformatf("vec%0d_frame_err", v), 32'(bus.frame_err), 1);
        check($sformatf("vec%0d_busy", v), 32'(bus.busy), 0);
        idle(1);
      end
    end
    // read held for 100 cycles
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h04);
    check_cmd("rd_hold", 1'b0, 32'h00001004, 32'h0);
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.cmd_valid || bus.cmd_addr !== 32'h00001004 || bus.cmd_write || bus.cmd_wdata !== 0 || bus.timeout_err) stable = 1'b0;
    end
    check("rd_hold_stable", 32'(stable), 1);
    accept();
    // bad header, then a good write frame
    send_byte(8'h41);
    exp_fe++;
    check("bad_hdr_pulse", 32'(bus.frame_err), 1);
    check("bad_hdr_busy", 32'(bus.busy), 0);
    idle(1);
    check("bad_hdr_pulse_end", 32'(bus.frame_err), 0);
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    check_cmd("after_bad", 1'b1, 32'h01020304, 32'h05060708);
    accept();
    // timeout after 57 AA BB
    send_byte(8'h57); send_byte(8'hAA); send_byte(8'hBB);
    idle(T - 1);
    check("to_early", 32'(bus.timeout_err), 0);
    check("to_busy_before", 32'(bus.busy), 1);
    idle(1);
    check("to_pulse", 32'(bus.timeout_err), 1);
    check("to_busy_after", 32'(bus.busy), 0);
    check("to_no_valid", 32'(bus.cmd_valid), 0);
    idle(1);
    check("to_pulse_end", 32'(bus.timeout_err), 0);
    // byte landing in the expiry cycle is accepted
    send_byte(8'h57); send_byte(8'hAA); send_byte(8'hBB);
    idle(T - 2);
    send_byte(8'hCC);
    check("expiry_no_to", 32'(bus.timeout_err), 0);
    check("expiry_busy", 32'(bus.busy), 1);
    send_byte(8'hDD); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check_cmd("expiry", 1'b1, 32'hAABBCCDD, 32'h11223344);
    // overrun with cmd_ready low, then in the accepting cycle
    send_byte(8'h57);
    check("ovr_pulse1", 32'(bus.overrun_err), 1);
    check("ovr_still_valid", 32'(bus.cmd_valid), 1);
    check("ovr_addr_held", bus.cmd_addr, 32'hAABBCCDD);
    @(negedge clk);
    bus.rx_data = 8'h57;
    bus.rx_data_valid = 1'b1;
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.rx_data_valid = 1'b0;
    bus.cmd_ready = 1'b0;
    check("ovr_pulse2", 32'(bus.overrun_err), 1);
    check("ovr_idle_valid", 32'(bus.cmd_valid), 0);
    idle(3);
    check("ovr_no_new_frame", 32'(bus.busy), 0);
    // reset mid-frame
    send_byte(8'h57); send_byte(8'h11); send_byte(8'h22);
    sa = 32'(fe_cnt + to_cnt + ov_cnt);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_busy", 32'(bus.busy), 0);
    check("mrst_addr", bus.cmd_addr, 0);
    check("mrst_write", 32'(bus.cmd_write), 0);
    check("mrst_valid", 32'(bus.cmd_valid), 0);
    idle(T + 5);
    sd = 32'(fe_cnt + to_cnt + ov_cnt);
    check("mrst_no_err", sd, sa);
    send_byte(8'h52); send_byte(8'hCA); send_byte(8'hFE); send_byte(8'h00); send_byte(8'h01);
    check_cmd("mrst_frame", 1'b0, 32'hCAFE0001, 32'h0);
    accept();
    idle(2);
    check("frame_err_count", 32'(fe_cnt), 32'(exp_fe));
    check("timeout_count", 32'(to_cnt), 1);
    check("overrun_count", 32'(ov_cnt), 2);
    check("err_exclusive", 32'(multi), 0);
    check("err_width", 32'(wide), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
